serial_frame_tx: RTL and testbench



---
 rtl/serial_frame_tx.sv | 71 +++++++
 tb/tb_serial_frame_tx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: framed bit-serial transmitter (start, LSB-first data, optional parity, stop)
// with a valid/ready word input and a registered, idle-high serial line.
module serial_frame_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              busy,
   output logic              done
);
   localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   state_t            r_state, w_next;
   logic [CW-1:0]     r_cnt, w_cnt_nxt;
   logic [BW-1:0]     r_bit, w_bit_nxt;
   logic [DATA_W-1:0] r_shift, w_shift_nxt;
   logic              r_par, r_out, r_busy, r_done;
   logic              w_last_cyc, w_last_bit, w_accept, w_out;
   always_comb begin
      w_last_cyc = r_cnt == CW'(CLKS_PER_BIT - 1);
      w_last_bit = r_bit == BW'(DATA_W - 1);
      w_accept   = r_state == S_IDLE && tx_valid;
      w_next     = S_IDLE;
      case (r_state)
         S_IDLE:   w_next = tx_valid ? S_START : S_IDLE;
         S_START:  w_next = w_last_cyc ? S_DATA : S_START;
         S_DATA:   w_next = !(w_last_cyc && w_last_bit) ? S_DATA : (PARITY_EN != 0) ? S_PARITY : S_STOP;
         S_PARITY: w_next = w_last_cyc ? S_STOP : S_PARITY;
         S_STOP:   w_next = w_last_cyc ? S_IDLE : S_STOP;
         default:  w_next = S_IDLE;
      endcase
      w_cnt_nxt   = (r_state == S_IDLE || w_last_cyc) ? '0 : r_cnt + CW'(1);
      w_bit_nxt   = (r_state == S_DATA && w_last_cyc) ? (w_last_bit ? '0 : r_bit + BW'(1)) : r_bit;
      // The shift register moves only at the end of a data bit, so bit 0 is still in place on START->DATA.
      w_shift_nxt = w_accept ? tx_data : (r_state == S_DATA && w_last_cyc) ? r_shift >> 1 : r_shift;
      w_out       = w_next == S_DATA ? w_shift_nxt[0] : w_next == S_PARITY ? r_par : w_next != S_START;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_out   <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_par   <= w_accept ? (^tx_data) ^ 1'(PARITY_ODD) : r_par;
         r_out   <= w_out;
         r_busy  <= w_next != S_IDLE;
         r_done  <= r_state == S_STOP && w_last_cyc;
      end
   end
   assign tx_ready = r_state == S_IDLE;
   assign tx_out   = r_out;
   assign busy     = r_busy;
   assign done     = r_done;
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: three transmitter configurations (default, odd parity, no parity at one
// clock per bit) checked cycle by cycle against a bit-sequence model of the frame.
module tb_serial_frame_tx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2:0] valid = '0, out, busy, done, rdy;
   logic [7:0] data [3];
   int cpb  [3] = '{4, 4, 1};
   int pen  [3] = '{1, 1, 0};
   int podd [3] = '{0, 1, 0};
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut0 (
      .clk(clk), .rst(rst), .tx_data(data[0]), .tx_valid(valid[0]), .tx_ready(rdy[0]),
      .tx_out(out[0]), .busy(busy[0]), .done(done[0]));
   serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut1 (
      .clk(clk), .rst(rst), .tx_data(data[1]), .tx_valid(valid[1]), .tx_ready(rdy[1]),
      .tx_out(out[1]), .busy(busy[1]), .done(done[1]));
   serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) dut2 (
      .clk(clk), .rst(rst), .tx_data(data[2]), .tx_valid(valid[2]), .tx_ready(rdy[2]),
      .tx_out(out[2]), .busy(busy[2]), .done(done[2]));

   // Sends word w on instance k; vin/scramble shape tx_valid/tx_data during the frame,
   // chain keeps tx_valid high with nxt in the done cycle for a back-to-back frame.
   task automatic frame(input int k, input logic [7:0] w, input bit vin, input bit chain,
                        input logic [7:0] nxt, input bit scramble);
      logic bits [$];
      logic exp [$];
      logic [7:0] rx = '0;
      int bad_line = 0, bad_busy = 0, bad_done = 0, bad_rdy = 0, first = -1;
      bits.push_back(1'b0);
      for (int b = 0; b < 8; b++) bits.push_back(w[b]);
      if (pen[k] != 0) bits.push_back((^w) ^ 1'(podd[k]));
      bits.push_back(1'b1);
      foreach (bits[j]) for (int c = 0; c < cpb[k]; c++) exp.push_back(bits[j]);
      checks++;
      if (rdy[k] !== 1'b1) begin
         errors++;
         $display("FAIL ready_before_frame dut%0d got %b expected 1", k, rdy[k]);
      end
      valid[k] = 1'b1;
      data[k]  = w;
      @(posedge clk);
      @(negedge clk);
      valid[k] = vin;
      for (int i = 0; i < exp.size(); i++) begin
         data[k] = scramble ? 8'($urandom) : nxt;
         if (out[k] !== exp[i]) begin
            bad_line++;
            if (first < 0) first = i;
         end
         if (busy[k] !== 1'b1) bad_busy++;
         if (done[k] !== 1'b0) bad_done++;
         if (rdy[k] !== 1'b0) bad_rdy++;
         if (i % cpb[k] == cpb[k] / 2 && i / cpb[k] >= 1 && i / cpb[k] <= 8) rx[i / cpb[k] - 1] = out[k];
         @(negedge clk);
      end
      checks += 5;
      if (bad_line != 0) begin
         errors++;
         $display("FAIL line dut%0d word %h: %0d bad cycles, first at frame cycle %0d, expected 0", k, w, bad_line, first);
      end
      if (bad_busy != 0) begin
         errors++;
         $display("FAIL busy_in_frame dut%0d word %h: %0d cycles low, expected 0", k, w, bad_busy);
      end
      if (bad_done != 0) begin
         errors++;
         $display("FAIL done_in_frame dut%0d word %h: %0d cycles high, expected 0", k, w, bad_done);
      end
      if (bad_rdy != 0) begin
         errors++;
         $display("FAIL ready_in_frame dut%0d word %h: %0d cycles high, expected 0", k, w, bad_rdy);
      end
      if (rx !== w) begin
         errors++;
         $display("FAIL rx_word dut%0d got %h expected %h", k, rx, w);
      end
      checks++;
      if ({out[k], busy[k], done[k], rdy[k]} !== 4'b1011) begin
         errors++;
         $display("FAIL done_cycle dut%0d {out,busy,done,ready} got %b expected 1011", k, {out[k], busy[k], done[k], rdy[k]});
      end
      valid[k] = chain;
      data[k]  = nxt;
      if (!chain) begin
         @(negedge clk);
         checks++;
         if ({out[k], busy[k], done[k], rdy[k]} !== 4'b1001) begin
            errors++;
            $display("FAIL after_done dut%0d {out,busy,done,ready} got %b expected 1001", k, {out[k], busy[k], done[k], rdy[k]});
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({out[k], busy[k], done[k], rdy[k]} !== 4'b1001) begin
            errors++;
            $display("FAIL reset dut%0d {out,busy,done,ready} got %b expected 1001", k, {out[k], busy[k], done[k], rdy[k]});
         end
      end
   endtask

   task automatic test_idle();
      int bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (out !== 3'b111 || busy !== 3'b000 || done !== 3'b000) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL idle_line: %0d cycles not idle, expected 0", bad);
      end
   endtask

   task automatic test_single();
      frame(0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0);
      frame(1, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0);
      frame(2, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0);
   endtask

   task automatic test_back_to_back();
      frame(0, 8'h3C, 1'b1, 1'b1, 8'hC3, 1'b0);
      frame(0, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0);
      frame(2, 8'h96, 1'b1, 1'b1, 8'h69, 1'b0);
      frame(2, 8'h69, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_stability();
      frame(0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_mid_reset();
      int bad = 0;
      valid[0] = 1'b1;
      data[0]  = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      valid[0] = 1'b0;
      repeat (12) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({out[0], busy[0], done[0], rdy[0]} !== 4'b1001) begin
         errors++;
         $display("FAIL mid_reset {out,busy,done,ready} got %b expected 1001", {out[0], busy[0], done[0], rdy[0]});
      end
      repeat (50) begin
         @(negedge clk);
         if (done[0] !== 1'b0 || out[0] !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL mid_reset_quiet: %0d cycles with done or low line, expected 0", bad);
      end
      frame(0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 3; k++) begin
         logic [7:0] w = 8'($urandom);
         for (int n = 0; n < 6; n++) begin
            logic [7:0] nw = 8'($urandom);
            bit ch = (n < 5) && ($urandom_range(0, 1) == 1);
            frame(k, w, 1'($urandom_range(0, 1)), ch, nw, 1'($urandom_range(0, 1)));
            w = nw;
         end
      end
   endtask

   initial begin
      data = '{8'h00, 8'h00, 8'h00};
      @(negedge clk);
      test_reset();
      test_idle();
      test_single();
      test_back_to_back();
      test_stability();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
